// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multi-cycle RISC-V main control FSM.
// Holds the state encoding, opcode constants, ALU op classes and the decoded control word.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_LUI    = 2'b11
    } alu_op_t;

    localparam logic [6:0] OP_HALT   = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RW_ALU = 2'b00;
    localparam logic [1:0] RW_PC4 = 2'b01;

    typedef struct packed {
        logic       alu_src;
        alu_op_t    alu_op;
        logic       branch;
        logic       jump;
        logic       jalr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] rw_sel;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the IR/memories and the datapath enables.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
    parameter int PERF_W = 32
);
    logic [6:0]        opcode;
    logic              imem_ready;
    logic              dmem_ready;
    logic              imem_req;
    logic              ir_write;
    logic              pc_write;
    logic              dmem_req;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              mem_to_reg;
    logic              reg_write;
    logic              branch;
    logic              jump;
    logic              jalr_sel;
    logic [1:0]        rw_sel;
    logic              halted;
    logic              illegal;
    logic              timeout;
    logic [2:0]        state_o;
    logic [PERF_W-1:0] cycle_cnt;
    logic [PERF_W-1:0] instret_cnt;

    modport master (
        input  opcode, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write,
               alu_src, alu_op, mem_to_reg, reg_write, branch, jump, jalr_sel,
               rw_sel, halted, illegal, timeout, state_o, cycle_cnt, instret_cnt
    );

    modport slave (
        output opcode, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write,
               alu_src, alu_op, mem_to_reg, reg_write, branch, jump, jalr_sel,
               rw_sel, halted, illegal, timeout, state_o, cycle_cnt, instret_cnt
    );

endinterface

// File: rtl/multicycle_controller_decode.sv
// Opcode -> control word table shared with the single-cycle control path.
// Purely combinational; the FSM decides in which state each field is allowed through.
module multicycle_controller_decode
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    output ctrl_word_t word,
    output logic       legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                word.alu_op    = ALU_FUNCT;
                word.reg_write = 1'b1;
            end
            OP_ITYPE: begin
                word.alu_src   = 1'b1;
                word.alu_op    = ALU_FUNCT;
                word.reg_write = 1'b1;
            end
            OP_LOAD: begin
                word.alu_src    = 1'b1;
                word.alu_op     = ALU_ADD;
                word.mem_read   = 1'b1;
                word.mem_to_reg = 1'b1;
                word.reg_write  = 1'b1;
            end
            OP_STORE: begin
                word.alu_src   = 1'b1;
                word.alu_op    = ALU_ADD;
                word.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                word.alu_op = ALU_BRANCH;
                word.branch = 1'b1;
            end
            OP_JAL: begin
                word.alu_src   = 1'b1;
                word.alu_op    = ALU_ADD;
                word.jump      = 1'b1;
                word.reg_write = 1'b1;
                word.rw_sel    = RW_PC4;
            end
            OP_JALR: begin
                word.alu_src   = 1'b1;
                word.alu_op    = ALU_FUNCT;
                word.jump      = 1'b1;
                word.jalr_sel  = 1'b1;
                word.reg_write = 1'b1;
                word.rw_sel    = RW_PC4;
            end
            OP_LUI: begin
                word.alu_src   = 1'b1;
                word.alu_op    = ALU_LUI;
                word.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB with wait-state timeout and sticky halt.
// Define CTRL_PERF_EN to build the cycle/instret performance counters; otherwise they read as zero.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int PERF_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t            state;
    state_t            state_next;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              halted_q;
    logic              illegal_q;
    logic              timeout_q;
    logic              set_halt;
    logic              set_illegal;
    logic              set_timeout;
    logic [6:0]        dec_op;
    ctrl_word_t        word;
    logic              legal;

    // The raw opcode only reaches the decoder in DECODE, where every output is gated off anyway.
    assign dec_op    = (state == DECODE) ? bus.opcode : op_q;
    assign wait_done = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    multicycle_controller_decode u_decode (
        .op    (dec_op),
        .word  (word),
        .legal (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                op_q <= bus.opcode;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == FETCH || state == MEM) && !wait_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (set_halt)    halted_q  <= 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
        end
    end

    // Ready always wins over the timeout check on the last permitted wait cycle.
    always_comb begin
        state_next     = state;
        set_halt       = 1'b0;
        set_illegal    = 1'b0;
        set_timeout    = 1'b0;
        bus.imem_req   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = 2'b00;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.branch     = 1'b0;
        bus.jump       = 1'b0;
        bus.jalr_sel   = 1'b0;
        bus.rw_sel     = RW_ALU;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_next   = DECODE;
                end else if (wait_done) begin
                    set_halt    = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = HALT;
                end
            end
            DECODE: begin
                if (bus.opcode == OP_HALT) begin
                    set_halt   = 1'b1;
                    state_next = HALT;
                end else if (!legal) begin
                    set_halt    = 1'b1;
                    set_illegal = 1'b1;
                    state_next  = HALT;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                bus.alu_src  = word.alu_src;
                bus.alu_op   = word.alu_op;
                bus.branch   = word.branch;
                bus.jump     = word.jump;
                bus.jalr_sel = word.jalr_sel;
                bus.pc_write = word.jump;
                if (word.branch)
                    state_next = FETCH;
                else if (word.mem_read || word.mem_write)
                    state_next = MEM;
                else
                    state_next = WB;
            end
            MEM: begin
                bus.dmem_req  = 1'b1;
                bus.mem_read  = word.mem_read;
                bus.mem_write = word.mem_write;
                bus.alu_src   = word.alu_src;
                bus.alu_op    = word.alu_op;
                if (bus.dmem_ready) begin
                    state_next = word.mem_read ? WB : FETCH;
                end else if (wait_done) begin
                    set_halt    = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = HALT;
                end
            end
            WB: begin
                bus.reg_write  = word.reg_write;
                bus.mem_to_reg = word.mem_to_reg;
                bus.rw_sel     = word.rw_sel;
                state_next     = FETCH;
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign bus.halted  = halted_q;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
    assign bus.state_o = state;

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_q;
    logic [PERF_W-1:0] instret_q;

    // An instruction retires when control returns to FETCH from any execute-side state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state != HALT) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (state_next == FETCH && (state == EXEC || state == MEM || state == WB)) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
`else
    assign bus.cycle_cnt   = {PERF_W{1'b0}};
    assign bus.instret_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (MAX_WAIT=4).
// Each scenario task drives one instruction pattern and compares outputs sampled on the falling edge.
module tb_multicycle_controller;

    localparam int PERF_W = 32;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    multicycle_controller_if #(.PERF_W(PERF_W)) bus ();

    multicycle_controller #(
        .MAX_WAIT (4),
        .PERF_W   (PERF_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Releases reset on a falling edge; the FSM is in IDLE on return and in FETCH one cycle later.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state_o); end
        vectors++;
        if ({bus.imem_req, bus.ir_write, bus.pc_write, bus.dmem_req, bus.reg_write, bus.mem_write} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_enables: got %b expected 000000",
                {bus.imem_req, bus.ir_write, bus.pc_write, bus.dmem_req, bus.reg_write, bus.mem_write});
        end
        vectors++;
        if ({bus.halted, bus.illegal, bus.timeout} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.halted, bus.illegal, bus.timeout});
        end
        vectors++;
        if (bus.cycle_cnt !== '0 || bus.instret_cnt !== '0) begin
            errors++; $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", bus.cycle_cnt, bus.instret_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.state_o !== 3'd1 || bus.imem_req !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_to_fetch: got state %0d req %b expected 1 1", bus.state_o, bus.imem_req);
        end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        logic       exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.opcode     = 7'b0110011;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.state_o !== exp_st[i]) begin errors++; $display("[TB] FAIL add_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
            vectors++;
            if (bus.reg_write !== exp_rw[i]) begin errors++; $display("[TB] FAIL add_reg_write[%0d]: got %b expected %b", i, bus.reg_write, exp_rw[i]); end
            if (i == 0) begin
                vectors++;
                if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
                    errors++; $display("[TB] FAIL add_fetch_en: got ir %b pc %b expected 1 1", bus.ir_write, bus.pc_write);
                end
            end
            if (i == 2) begin
                vectors++;
                if (bus.alu_op !== 2'b10 || bus.alu_src !== 1'b0) begin
                    errors++; $display("[TB] FAIL add_exec_alu: got op %b src %b expected 10 0", bus.alu_op, bus.alu_src);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0] exp_st [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
        logic       in_mem;
        bus.opcode     = 7'b0000011;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.dmem_ready = (i == 6);
            in_mem = (i >= 3 && i <= 6);
            vectors++;
            if (bus.state_o !== exp_st[i]) begin errors++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
            vectors++;
            if (bus.dmem_req !== in_mem || bus.mem_read !== in_mem) begin
                errors++; $display("[TB] FAIL lw_mem_req[%0d]: got req %b rd %b expected %b", i, bus.dmem_req, bus.mem_read, in_mem);
            end
            if (i == 7) begin
                vectors++;
                if (bus.mem_to_reg !== 1'b1 || bus.reg_write !== 1'b1) begin
                    errors++; $display("[TB] FAIL lw_wb: got m2r %b rw %b expected 1 1", bus.mem_to_reg, bus.reg_write);
                end
            end
        end
`ifdef CTRL_PERF_EN
        vectors++;
        if (bus.instret_cnt !== 32'd1) begin errors++; $display("[TB] FAIL lw_instret: got %0d expected 1", bus.instret_cnt); end
`endif
    endtask

    task automatic test_beq();
        logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
        bus.opcode     = 7'b1100011;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.state_o !== exp_st[i]) begin errors++; $display("[TB] FAIL beq_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
            vectors++;
            if (bus.reg_write !== 1'b0 || bus.branch !== (i == 2)) begin
                errors++; $display("[TB] FAIL beq_ctrl[%0d]: got rw %b br %b expected 0 %b", i, bus.reg_write, bus.branch, (i == 2));
            end
            if (i == 2) begin
                vectors++;
                if (bus.alu_op !== 2'b01) begin errors++; $display("[TB] FAIL beq_alu_op: got %b expected 01", bus.alu_op); end
            end
        end
    endtask

    task automatic test_jal();
        logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        bus.opcode     = 7'b1101111;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.state_o !== exp_st[i]) begin errors++; $display("[TB] FAIL jal_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
            if (i == 2) begin
                vectors++;
                if (bus.pc_write !== 1'b1 || bus.jump !== 1'b1 || bus.jalr_sel !== 1'b0) begin
                    errors++; $display("[TB] FAIL jal_exec: got pcw %b jump %b jalr %b expected 1 1 0", bus.pc_write, bus.jump, bus.jalr_sel);
                end
            end
            if (i == 3) begin
                vectors++;
                if (bus.rw_sel !== 2'b01 || bus.reg_write !== 1'b1 || bus.pc_write !== 1'b0) begin
                    errors++; $display("[TB] FAIL jal_wb: got sel %b rw %b pcw %b expected 01 1 0", bus.rw_sel, bus.reg_write, bus.pc_write);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bus.opcode     = 7'b0110011;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.state_o !== 3'd1 || bus.imem_req !== 1'b1 || bus.timeout !== 1'b0) begin
                errors++; $display("[TB] FAIL timeout_wait[%0d]: got state %0d req %b to %b expected 1 1 0", i, bus.state_o, bus.imem_req, bus.timeout);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.imem_ready = 1'b1;
            vectors++;
            if (bus.state_o !== 3'd6 || bus.timeout !== 1'b1 || bus.imem_req !== 1'b0) begin
                errors++; $display("[TB] FAIL timeout_halt[%0d]: got state %0d to %b req %b expected 6 1 0", i, bus.state_o, bus.timeout, bus.imem_req);
            end
        end
    endtask

    task automatic test_illegal();
        bus.opcode     = 7'h7F;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        apply_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.state_o !== 3'd6) begin errors++; $display("[TB] FAIL illegal_state: got %0d expected 6", bus.state_o); end
        vectors++;
        if ({bus.halted, bus.illegal, bus.timeout} !== 3'b110) begin
            errors++; $display("[TB] FAIL illegal_flags: got %b expected 110", {bus.halted, bus.illegal, bus.timeout});
        end
    endtask

    task automatic test_halt_opcode();
        bus.opcode     = 7'h00;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        apply_reset();
        repeat (3) @(negedge clk);
        bus.opcode = 7'b0110011;
        vectors++;
        if (bus.state_o !== 3'd6 || {bus.halted, bus.illegal} !== 2'b10) begin
            errors++; $display("[TB] FAIL halt_entry: got state %0d flags %b expected 6 10", bus.state_o, {bus.halted, bus.illegal});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.state_o !== 3'd6 || bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL halt_sticky: got state %0d halted %b req %b expected 6 1 0", bus.state_o, bus.halted, bus.imem_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_st [9] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        bus.opcode     = 7'b0110111;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 2) bus.opcode = 7'b0100011;
            vectors++;
            if (bus.state_o !== exp_st[i]) begin errors++; $display("[TB] FAIL b2b_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
            vectors++;
            if (bus.mem_write !== (i == 7) || bus.reg_write !== (i == 3)) begin
                errors++; $display("[TB] FAIL b2b_writes[%0d]: got mw %b rw %b expected %b %b", i, bus.mem_write, bus.reg_write, (i == 7), (i == 3));
            end
            if (i == 2) begin
                vectors++;
                if (bus.alu_op !== 2'b11 || bus.alu_src !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_lui_alu: got op %b src %b expected 11 1", bus.alu_op, bus.alu_src);
                end
            end
            if (i == 6) begin
                vectors++;
                if (bus.alu_op !== 2'b00 || bus.alu_src !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_sw_alu: got op %b src %b expected 00 1", bus.alu_op, bus.alu_src);
                end
            end
        end
`ifdef CTRL_PERF_EN
        vectors++;
        if (bus.instret_cnt !== 32'd2) begin errors++; $display("[TB] FAIL b2b_instret: got %0d expected 2", bus.instret_cnt); end
`endif
    endtask

    task automatic test_reset_mid_mem();
        bus.opcode     = 7'b0100011;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        apply_reset();
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.state_o !== 3'd4 || bus.dmem_req !== 1'b1 || bus.mem_write !== 1'b1) begin
            errors++; $display("[TB] FAIL midmem_pre: got state %0d req %b mw %b expected 4 1 1", bus.state_o, bus.dmem_req, bus.mem_write);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bus.state_o !== 3'd0 || bus.dmem_req !== 1'b0 || bus.mem_write !== 1'b0 || bus.alu_src !== 1'b0) begin
            errors++; $display("[TB] FAIL midmem_reset: got state %0d req %b mw %b src %b expected 0 0 0 0",
                bus.state_o, bus.dmem_req, bus.mem_write, bus.alu_src);
        end
        vectors++;
        if (bus.cycle_cnt !== '0 || bus.instret_cnt !== '0) begin
            errors++; $display("[TB] FAIL midmem_perf: got %0d/%0d expected 0/0", bus.cycle_cnt, bus.instret_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.opcode     = 7'h00;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_jal();
        test_timeout();
        test_illegal();
        test_halt_opcode();
        test_back_to_back();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
